// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: request opcodes and FSM state encodings.
package dmem_arbiter_pkg;

    localparam int WORD_SIZE = 32;

    localparam logic [1:0] DMEM_OP_READ   = 2'b00;
    localparam logic [1:0] DMEM_OP_WRITE  = 2'b01;
    localparam logic [1:0] DMEM_OP_AMOADD = 2'b10;

    localparam logic [0:0] DARB_ARB    = 1'b0;
    localparam logic [0:0] DARB_AMO_WR = 1'b1;

    // Opcode 2'b11 is not a store, so it falls through as a read.
    function automatic logic op_is_write(input logic [1:0] op);
        return op == DMEM_OP_WRITE;
    endfunction

    function automatic logic op_is_amo(input logic [1:0] op);
        return op == DMEM_OP_AMOADD;
    endfunction

endpackage

// File: rtl/dmem_prio_arb.sv
// Fixed-priority two-way arbiter (r0 preferred) with a starvation counter that
// hands the slot to r1 once it has waited STARVE_LIMIT cycles.
module dmem_prio_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       r0_valid,
    input  logic       r1_valid,
    output logic [1:0] grant
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_MAX) && r1_valid;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (r0_valid && !starved) begin
                grant = 2'b01;
            end else if (r1_valid) begin
                grant = 2'b10;
            end
        end
    end

    // Counts every cycle r1 is left waiting, including lock cycles when en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!r1_valid || grant[1]) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the load/store unit (r0) and the
// DMA/debug port (r1); sequences the two-cycle atomic fetch-and-add under lock.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = WORD_SIZE,
    parameter int DATA_W       = WORD_SIZE,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [1:0]        r0_op,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_rsp_valid,
    output logic [DATA_W-1:0] r0_rsp_rdata,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [1:0]        r1_op,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rsp_valid,
    output logic [DATA_W-1:0] r1_rsp_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              amo_busy
);

    logic [0:0]        state;
    logic [ADDR_W-1:0] amo_addr_q;
    logic [DATA_W-1:0] amo_opnd_q;
    logic [1:0]        rsp_q;
    logic [1:0]        grant;
    logic              in_arb;
    logic              granted;
    logic [1:0]        sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign in_arb = !rst && (state == DARB_ARB);

    dmem_prio_arb #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (in_arb),
        .r0_valid(r0_valid),
        .r1_valid(r1_valid),
        .grant   (grant)
    );

    assign granted   = |grant;
    assign sel_op    = grant[1] ? r1_op    : r0_op;
    assign sel_addr  = grant[1] ? r1_addr  : r0_addr;
    assign sel_wdata = grant[1] ? r1_wdata : r0_wdata;

    assign r0_ready = grant[0];
    assign r1_ready = grant[1];

    // The AMO write-back uses the old value returned by the read issued one cycle earlier.
    always_comb begin
        mem_we = granted && op_is_write(sel_op);
        mem_a  = sel_addr;
        mem_wd = sel_wdata;
        if (state == DARB_AMO_WR) begin
            mem_we = !rst;
            mem_a  = amo_addr_q;
            mem_wd = mem_rd + amo_opnd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DARB_ARB;
            rsp_q      <= 2'b00;
            amo_addr_q <= '0;
            amo_opnd_q <= '0;
        end else begin
            rsp_q <= grant;
            if (state == DARB_AMO_WR) begin
                state <= DARB_ARB;
            end else if (granted && op_is_amo(sel_op)) begin
                state      <= DARB_AMO_WR;
                amo_addr_q <= sel_addr;
                amo_opnd_q <= sel_wdata;
            end
        end
    end

    assign r0_rsp_valid = rsp_q[0] && !rst;
    assign r1_rsp_valid = rsp_q[1] && !rst;
    assign r0_rsp_rdata = mem_rd;
    assign r1_rsp_rdata = mem_rd;
    assign amo_busy     = !rst && (state == DARB_AMO_WR);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter with an in-bench data memory and
// a transaction-level reference model of grants, memory contents and responses.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int LIM   = 4;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_valid, r0_ready, r0_rsp_valid;
    logic [1:0]    r0_op;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rsp_rdata;
    logic          r1_valid, r1_ready, r1_rsp_valid;
    logic [1:0]    r1_op;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rsp_rdata;
    logic          mem_we, amo_busy;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .amo_busy(amo_busy)
    );

    // Single-port memory: registered read, read-before-write.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        mem_rd <= mem[mem_a];
        if (mem_we) mem[mem_a] <= mem_wd;
    end

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] gold [DEPTH];
    int            wait_c;
    bit            busy;
    logic [AW-1:0] amo_a;
    logic [DW-1:0] amo_o;
    bit            pv [2];
    logic [DW-1:0] pd [2];

    // Values sampled in the most recent cycle, for the directed checks
    logic          s_r0_ready, s_r1_ready, s_busy, s_we, s_rv0, s_rv1;
    logic [DW-1:0] s_wd, s_rd0, s_rd1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock cycle: called just after a negedge, drives inputs, checks outputs
    // against the model, advances the model, and returns at the next negedge.
    task automatic cyc(input bit rs,
                       input bit v0, input logic [1:0] o0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit v1, input logic [1:0] o1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bit            er0, er1, ebusy, ewe, chk_a;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        bit            nv [2];
        logic [DW-1:0] nd [2];
        int            g;
        logic [1:0]    op;
        logic [AW-1:0] ad;
        logic [DW-1:0] dt;

        rst = rs;
        r0_valid = v0; r0_op = o0; r0_addr = a0; r0_wdata = d0;
        r1_valid = v1; r1_op = o1; r1_addr = a1; r1_wdata = d1;
        #1;

        er0 = 0; er1 = 0; ebusy = 0; ewe = 0; chk_a = 0; ea = '0; ewd = '0;
        nv[0] = 0; nv[1] = 0; nd[0] = '0; nd[1] = '0;
        if (!rs) begin
            if (busy) begin
                ebusy = 1; ewe = 1; chk_a = 1; ea = amo_a;
                ewd = gold[amo_a] + amo_o;
                gold[amo_a] = ewd;
                busy = 0;
                wait_c = v1 ? ((wait_c < LIM) ? wait_c + 1 : LIM) : 0;
            end else begin
                g = -1;
                if (v0 && !(wait_c == LIM && v1)) g = 0;
                else if (v1) g = 1;
                if (g >= 0) begin
                    op = (g == 1) ? o1 : o0;
                    ad = (g == 1) ? a1 : a0;
                    dt = (g == 1) ? d1 : d0;
                    er0 = (g == 0); er1 = (g == 1);
                    chk_a = 1; ea = ad;
                    ewe = (op == DMEM_OP_WRITE); ewd = dt;
                    nv[g] = 1; nd[g] = gold[ad];
                    if (op == DMEM_OP_WRITE) gold[ad] = dt;
                    if (op == DMEM_OP_AMOADD) begin
                        busy = 1; amo_a = ad; amo_o = dt;
                    end
                end
                wait_c = (v1 && g != 1) ? ((wait_c < LIM) ? wait_c + 1 : LIM) : 0;
            end
        end

        chk("r0_ready", DW'(r0_ready), DW'(er0));
        chk("r1_ready", DW'(r1_ready), DW'(er1));
        chk("amo_busy", DW'(amo_busy), DW'(ebusy));
        chk("mem_we", DW'(mem_we), DW'(ewe));
        chk("r0_rsp_valid", DW'(r0_rsp_valid), DW'(!rs && pv[0]));
        chk("r1_rsp_valid", DW'(r1_rsp_valid), DW'(!rs && pv[1]));
        if (chk_a) chk("mem_a", DW'(mem_a), DW'(ea));
        if (ewe) chk("mem_wd", mem_wd, ewd);
        if (!rs && pv[0]) chk("r0_rsp_rdata", r0_rsp_rdata, pd[0]);
        if (!rs && pv[1]) chk("r1_rsp_rdata", r1_rsp_rdata, pd[1]);

        s_r0_ready = r0_ready; s_r1_ready = r1_ready; s_busy = amo_busy; s_we = mem_we;
        s_wd = mem_wd; s_rv0 = r0_rsp_valid; s_rv1 = r1_rsp_valid;
        s_rd0 = r0_rsp_rdata; s_rd1 = r1_rsp_rdata;

        if (rs) begin
            busy = 0; wait_c = 0;
        end
        pv[0] = nv[0]; pv[1] = nv[1]; pd[0] = nd[0]; pd[1] = nd[1];
        @(negedge clk);
    endtask

    task automatic idle(input bit rs);
        cyc(rs, 0, DMEM_OP_READ, '0, '0, 0, DMEM_OP_READ, '0, '0);
    endtask

    task automatic req0(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc(0, 1, op, a, d, 0, DMEM_OP_READ, '0, '0);
    endtask

    task automatic req1(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc(0, 0, DMEM_OP_READ, '0, '0, 1, op, a, d);
    endtask

    logic [9:0] seq_r1, seq_rv1;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            gold[i] = '0;
        end
        wait_c = 0; busy = 0; amo_a = '0; amo_o = '0;
        pv[0] = 0; pv[1] = 0; pd[0] = '0; pd[1] = '0;
        rst = 1; r0_valid = 0; r1_valid = 0;
        r0_op = '0; r1_op = '0; r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
        @(negedge clk);

        // Reset holds everything quiet, then r0 wins the first free cycle
        cyc(1, 1, DMEM_OP_READ, 1, '0, 1, DMEM_OP_READ, 2, '0);
        cyc(1, 1, DMEM_OP_READ, 1, '0, 1, DMEM_OP_READ, 2, '0);
        chk("t1_rst_ready0", DW'(s_r0_ready), 0);
        chk("t1_rst_we", DW'(s_we), 0);
        cyc(0, 1, DMEM_OP_READ, 1, '0, 1, DMEM_OP_READ, 2, '0);
        chk("t1_first_grant_r0", DW'(s_r0_ready), 1);
        chk("t1_first_grant_not_r1", DW'(s_r1_ready), 0);
        idle(0);

        // Write then read back-to-back
        req0(DMEM_OP_WRITE, 5, 32'hAA);
        req0(DMEM_OP_READ, 5, '0);
        chk("t2_write_rsp", DW'(s_rv0), 1);
        idle(0);
        chk("t2_read_rsp", DW'(s_rv0), 1);
        chk("t2_read_data", s_rd0, 32'hAA);

        // Starvation rotation with both requesters always busy
        idle(0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, DMEM_OP_READ, AW'(i), '0, 1, DMEM_OP_READ, AW'(i + 16), '0);
            seq_r1[i] = s_r1_ready;
            seq_rv1[i] = s_rv1;
        end
        chk("t3_r1_grant_pattern", DW'(seq_r1), 32'h210);
        chk("t3_r1_rsp_pattern", DW'(seq_rv1), 32'h020);
        idle(0);
        chk("t3_r1_last_rsp", DW'(s_rv1), 1);

        // Fetch-and-add
        req0(DMEM_OP_WRITE, 8, 32'd10);
        idle(0);
        req1(DMEM_OP_AMOADD, 8, 32'd3);
        cyc(0, 1, DMEM_OP_READ, 1, '0, 1, DMEM_OP_READ, 1, '0);
        chk("t4_amo_busy", DW'(s_busy), 1);
        chk("t4_amo_ready0", DW'(s_r0_ready), 0);
        chk("t4_amo_ready1", DW'(s_r1_ready), 0);
        chk("t4_amo_we", DW'(s_we), 1);
        chk("t4_amo_wd", s_wd, 32'd13);
        chk("t4_amo_old", s_rd1, 32'd10);
        req0(DMEM_OP_READ, 8, '0);
        idle(0);
        chk("t4_amo_readback", s_rd0, 32'd13);
        req0(DMEM_OP_WRITE, 9, 32'hFFFF_FFFF);
        req0(DMEM_OP_AMOADD, 9, 32'd1);
        idle(0);
        chk("t4_wrap_wd", s_wd, 32'd0);
        chk("t4_wrap_old", s_rd0, 32'hFFFF_FFFF);

        // Reset landing on the lock cycle cancels the write-back
        req0(DMEM_OP_WRITE, 8, 32'd10);
        req0(DMEM_OP_AMOADD, 8, 32'd5);
        idle(1);
        chk("t5_rst_we", DW'(s_we), 0);
        chk("t5_rst_rsp", DW'(s_rv0), 0);
        req0(DMEM_OP_READ, 8, '0);
        idle(0);
        chk("t5_mem_unchanged", s_rd0, 32'd10);

        // Ordering across requesters
        req1(DMEM_OP_WRITE, 3, 32'd7);
        req0(DMEM_OP_READ, 3, '0);
        idle(0);
        chk("t6_write_then_read", s_rd0, 32'd7);
        req0(DMEM_OP_WRITE, 4, 32'h55);
        req0(DMEM_OP_READ, 4, '0);
        req1(DMEM_OP_WRITE, 4, 32'd9);
        chk("t6_read_then_write", s_rd0, 32'h55);
        idle(0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [DW-1:0] d0, d1;
            d0 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : DW'($urandom);
            d1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : DW'($urandom);
            cyc($urandom_range(0, 49) == 0,
                $urandom_range(0, 9) < 7, 2'($urandom), AW'($urandom_range(0, 7)), d0,
                $urandom_range(0, 9) < 7, 2'($urandom), AW'($urandom_range(0, 7)), d1);
        end
        idle(0);
        idle(0);
        idle(0);

        for (int i = 0; i < DEPTH; i++) begin
            chk("final_mem", mem[i], gold[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
